// File: rtl/subleq_pkg.sv
// Shared constants for the SUBLEQ engine: default parameters and the
// one-hot state encoding used by the sequencer.
package subleq_pkg;

   // Default parameter values
   localparam int DEF_DW         = 32;
   localparam int DEF_AW         = 32;
   localparam int DEF_WORD_BYTES = 4;
   localparam int DEF_RESET_PC   = 0;
   localparam int DEF_BR_LEQ     = 1;

   // One-hot state encoding, one bit per memory access phase plus HALT
   localparam int STATE_W = 7;
   localparam logic [STATE_W-1:0] ST_FETCH_A = 7'b000_0001;
   localparam logic [STATE_W-1:0] ST_FETCH_B = 7'b000_0010;
   localparam logic [STATE_W-1:0] ST_FETCH_C = 7'b000_0100;
   localparam logic [STATE_W-1:0] ST_READ_A  = 7'b000_1000;
   localparam logic [STATE_W-1:0] ST_READ_B  = 7'b001_0000;
   localparam logic [STATE_W-1:0] ST_WRITE_B = 7'b010_0000;
   localparam logic [STATE_W-1:0] ST_HALT    = 7'b100_0000;

endpackage

// File: rtl/subleq_engine.sv
// Single-instruction (SUBLEQ) engine. Each instruction is three operand
// words {A, B, C}: mem[B] = mem[B] - mem[A]; branch to C when the result
// is <= 0 (or < 0 when BR_LEQ = 0). Every phase is one memory access over
// a req/ack handshake, so a zero-wait memory retires one instruction
// every six cycles. A taken branch to itself stops the engine.
module subleq_engine
   import subleq_pkg::*;
#(
   parameter int DW         = DEF_DW,
   parameter int AW         = DEF_AW,
   parameter int WORD_BYTES = DEF_WORD_BYTES,
   parameter int RESET_PC   = DEF_RESET_PC,
   parameter int BR_LEQ     = DEF_BR_LEQ
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          halted,
   output logic [AW-1:0] pc_out,
   output logic [31:0]   instr_count
);

   localparam logic [AW-1:0] STEP1  = AW'(WORD_BYTES);
   localparam logic [AW-1:0] STEP2  = AW'(2 * WORD_BYTES);
   localparam logic [AW-1:0] STEP3  = AW'(3 * WORD_BYTES);
   localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

   logic [STATE_W-1:0] state_q, state_d;
   logic [AW-1:0]      pc_q, pc_d;
   logic [AW-1:0]      opa_q, opa_d;
   logic [AW-1:0]      opb_q, opb_d;
   logic [AW-1:0]      opc_q, opc_d;
   logic [DW-1:0]      da_q, da_d;     // mem[opA]
   logic [DW-1:0]      db_q, db_d;     // mem[opB]
   logic               halted_q, halted_d;
   logic [31:0]        cnt_q, cnt_d;

   logic [DW-1:0]      r;
   logic               r_neg;
   logic               r_zero;
   logic               taken;
   logic               fire;

   // Subtract result and branch decision; operand registers are stable
   // from READ_B onward, so r is steady through the whole WRITE_B wait.
   always_comb begin
      r      = db_q - da_q;
      r_neg  = r[DW-1];
      r_zero = (r == '0);
      taken  = (BR_LEQ != 0) ? (r_neg | r_zero) : r_neg;
   end

   // Memory access decode: all outputs come from registered state, so
   // they hold still for as long as the slave withholds ack.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_FETCH_A: begin
            mem_req  = en;
            mem_addr = pc_q;
         end
         ST_FETCH_B: begin
            mem_req  = 1'b1;
            mem_addr = pc_q + STEP1;
         end
         ST_FETCH_C: begin
            mem_req  = 1'b1;
            mem_addr = pc_q + STEP2;
         end
         ST_READ_A: begin
            mem_req  = 1'b1;
            mem_addr = opa_q;
         end
         ST_READ_B: begin
            mem_req  = 1'b1;
            mem_addr = opb_q;
         end
         ST_WRITE_B: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = opb_q;
            mem_wdata = r;
         end
         default: ;
      endcase
      // Reset kills any access in flight, including a coincident ack.
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
      end
      if (!mem_req) mem_wdata = '0;
   end

   assign fire = mem_req & mem_ack;

   // Sequencer: advance one phase per completed access, capture read data.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      opc_d    = opc_q;
      da_d     = da_q;
      db_d     = db_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      if (fire) begin
         case (state_q)
            ST_FETCH_A: begin
               opa_d   = mem_rdata[AW-1:0];
               state_d = ST_FETCH_B;
            end
            ST_FETCH_B: begin
               opb_d   = mem_rdata[AW-1:0];
               state_d = ST_FETCH_C;
            end
            ST_FETCH_C: begin
               opc_d   = mem_rdata[AW-1:0];
               state_d = ST_READ_A;
            end
            ST_READ_A: begin
               da_d    = mem_rdata;
               state_d = ST_READ_B;
            end
            ST_READ_B: begin
               db_d    = mem_rdata;
               state_d = ST_WRITE_B;
            end
            ST_WRITE_B: begin
               cnt_d = cnt_q + 32'd1;
               if (taken && (opc_q == pc_q)) begin
                  // Branch-to-self is the stop idiom; pc stays put.
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d    = taken ? opc_q : (pc_q + STEP3);
                  state_d = ST_FETCH_A;
               end
            end
            default: ;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FETCH_A;
         pc_q     <= PC_RST;
         opa_q    <= '0;
         opb_q    <= '0;
         opc_q    <= '0;
         da_q     <= '0;
         db_q     <= '0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         opc_q    <= opc_d;
         da_q     <= da_d;
         db_q     <= db_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   assign halted      = halted_q;
   assign pc_out      = pc_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_subleq_engine.sv
// Bench for subleq_engine: a 32-bit instance on a 1 KB memory with a
// programmable ack delay, checked against an instruction-level model, and
// an 8-bit instance (BR_LEQ = 0) on a zero-wait memory.
module tb_subleq_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic        mem_req, mem_we, mem_ack, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instr_count;

   logic        en8 = 1'b0;
   logic        req8, we8, ack8, halted8;
   logic [7:0]  addr8, wdata8, rdata8, pc8;
   logic [31:0] cnt8;

   int n_chk  = 0;
   int n_pass = 0;

   // Single comparison point: counts and reports.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   subleq_engine #(.DW(32), .AW(32), .WORD_BYTES(4), .RESET_PC(0), .BR_LEQ(1)) dut (
      .clk(clk), .rst(rst), .en(en),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .halted(halted), .pc_out(pc_out), .instr_count(instr_count)
   );

   subleq_engine #(.DW(8), .AW(8), .WORD_BYTES(4), .RESET_PC(0), .BR_LEQ(0)) dut8 (
      .clk(clk), .rst(rst), .en(en8),
      .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
      .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(ack8),
      .halted(halted8), .pc_out(pc8), .instr_count(cnt8)
   );

   // 32-bit memory: ack after wait_n idle request cycles
   logic [31:0] mem [256];
   int wait_n = 0;
   int wcnt   = 0;
   assign mem_rdata = mem[mem_addr[9:2]];
   assign mem_ack   = mem_req && (wcnt == wait_n);
   always @(posedge clk) begin
      if (mem_req && mem_ack) begin
         if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
         wcnt <= 0;
      end else if (mem_req) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   // 8-bit zero-wait memory
   logic [7:0] mem8 [64];
   assign rdata8 = mem8[addr8[7:2]];
   assign ack8   = req8;
   always @(posedge clk) if (req8 && we8) mem8[addr8[7:2]] = wdata8;

   // Request outputs must hold while a request waits for ack
   logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   always @(negedge clk) begin
      if (p_req && !p_ack && mem_req && !rst) begin
         chk("hold_addr", mem_addr, p_addr);
         chk("hold_we", mem_we, p_we);
         chk("hold_wdata", mem_wdata, p_wdata);
      end
      p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
      p_addr = mem_addr; p_wdata = mem_wdata;
   end

   // Instruction-level reference model
   logic [31:0] ref_mem [256];
   logic [31:0] ref_pc;
   logic        ref_halt;

   function automatic int wi(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   task automatic model_run(input int nmax, output int steps);
      logic [31:0] a, b, c, r;
      logic tk;
      ref_pc = 32'h0; ref_halt = 1'b0; steps = 0;
      while (steps < nmax && !ref_halt) begin
         a = ref_mem[wi(ref_pc)];
         b = ref_mem[wi(ref_pc + 4)];
         c = ref_mem[wi(ref_pc + 8)];
         r = ref_mem[wi(b)] - ref_mem[wi(a)];
         ref_mem[wi(b)] = r;
         tk = ($signed(r) <= 0);
         steps++;
         if (tk && c == ref_pc) ref_halt = 1'b1;
         else ref_pc = tk ? c : ref_pc + 32'd12;
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic put_instr(input int pc, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
      mem[pc/4] = a; mem[pc/4 + 1] = b; mem[pc/4 + 2] = c;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   // Reset, run the loaded program for up to nmax instructions, compare.
   task automatic run_prog(input string tag, input int nmax, input int w);
      int steps, cyc, nbad, budget;
      ref_mem = mem;
      model_run(nmax, steps);
      wait_n = w;
      en = 1'b0;
      @(negedge clk); rst = 1'b1; en = 1'b1;
      @(negedge clk); @(negedge clk);
      chk({tag, "_rst_req"}, mem_req, 1'b0);
      en = 1'b0; rst = 1'b0;
      #1;
      chk({tag, "_rst_pc"}, pc_out, 32'h0);
      chk({tag, "_rst_cnt"}, instr_count, 32'h0);
      en = 1'b1;
      cyc = 0;
      budget = steps * 6 * (w + 1) + 20;
      while (instr_count != steps && cyc < budget) begin
         @(posedge clk); cyc++;
         @(negedge clk);
      end
      en = 1'b0;
      chk({tag, "_cycles"}, cyc, steps * 6 * (w + 1));
      chk({tag, "_pc"}, pc_out, ref_pc);
      chk({tag, "_cnt"}, instr_count, steps);
      chk({tag, "_halted"}, halted, ref_halt);
      nbad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
      chk({tag, "_mem"}, nbad, 0);
   endtask

   initial begin
      int k, bad, nins, nmax, w;
      logic [31:0] c;

      // Reset with enables high: no requests, registers cleared
      rst = 1'b1; en = 1'b1; en8 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req32", mem_req, 1'b0);
      chk("rst_req8", req8, 1'b0);
      chk("rst_we32", mem_we, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_cnt8", cnt8, 32'h0);
      en = 1'b0; en8 = 1'b0; rst = 1'b0;

      // en low at FETCH_A: nothing requested
      bad = 0;
      repeat (10) begin @(negedge clk); if (mem_req || req8) bad++; end
      chk("en_low_idle", bad, 0);

      // 8-bit instance, BR_LEQ=0: 0x80-0x01=0x7F not taken; 5-5=0 not taken
      for (int i = 0; i < 64; i++) mem8[i] = '0;
      mem8[0] = 8'h40; mem8[1] = 8'h44; mem8[2] = 8'h80;
      mem8[3] = 8'h48; mem8[4] = 8'h4C; mem8[5] = 8'h30;
      mem8[16] = 8'h01; mem8[17] = 8'h80; mem8[18] = 8'h05; mem8[19] = 8'h05;
      en8 = 1'b1;
      #1 chk("dw8_req_on_en", req8, 1'b1);
      k = 0;
      while (cnt8 != 2 && k < 40) begin
         @(posedge clk); k++;
         @(negedge clk);
         if (k == 6) chk("dw8_pc1", pc8, 8'h0C);
      end
      en8 = 1'b0;
      chk("dw8_cycles", k, 12);
      chk("dw8_wr1", mem8[17], 8'h7F);
      chk("dw8_wr2", mem8[19], 8'h00);
      chk("dw8_pc2", pc8, 8'h18);

      // Basic instruction, zero wait: 10-3=7, not taken
      clear_mem();
      put_instr(0, 32'h40, 32'h44, 32'h100);
      mem[16] = 32'd3; mem[17] = 32'd10;
      run_prog("basic", 1, 0);
      chk("basic_wr", mem[17], 32'd7);
      chk("basic_pc", pc_out, 32'h0C);

      // r = 0 branches with BR_LEQ=1
      clear_mem();
      put_instr(0, 32'h40, 32'h44, 32'h100);
      mem[16] = 32'd10; mem[17] = 32'd10;
      run_prog("zero", 1, 0);
      chk("zero_pc", pc_out, 32'h100);

      // Three wait cycles per access: 24 cycles, same result
      clear_mem();
      put_instr(0, 32'h40, 32'h44, 32'h100);
      mem[16] = 32'd3; mem[17] = 32'd10;
      run_prog("wait3", 1, 3);
      chk("wait3_wr", mem[17], 32'd7);

      // Jump to 0x20, which branches to itself with r=-5: halt
      clear_mem();
      put_instr(0, 32'h40, 32'h44, 32'h20);
      put_instr(32'h20, 32'h48, 32'h4C, 32'h20);
      mem[16] = 32'd10; mem[17] = 32'd10; mem[18] = 32'd5; mem[19] = 32'd0;
      run_prog("halt", 10, 0);
      chk("halt_wr", mem[19], 32'hFFFF_FFFB);
      en = 1'b1;
      bad = 0;
      repeat (100) begin @(negedge clk); if (mem_req) bad++; end
      en = 1'b0;
      chk("halt_quiet", bad, 0);
      chk("halt_cnt", instr_count, 32'd2);
      chk("halt_pc", pc_out, 32'h20);
      chk("halt_flag", halted, 1'b1);

      // Reset during a waiting READ_B aborts without writing
      clear_mem();
      put_instr(0, 32'h40, 32'h44, 32'h100);
      mem[16] = 32'd3; mem[17] = 32'd10;
      wait_n = 3;
      do_reset();
      en = 1'b1;
      k = 0;
      while (!(mem_req && !mem_we && mem_addr == 32'h44) && k < 100) begin
         @(negedge clk); k++;
      end
      chk("abort_reach", k < 100, 1'b1);
      @(negedge clk);
      chk("abort_pending", mem_ack, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_req", mem_req, 1'b0);
      chk("abort_pc", pc_out, 32'h0);
      rst = 1'b0;
      #1;
      chk("abort_refetch", mem_req, 1'b1);
      chk("abort_addr", mem_addr, 32'h0);
      chk("abort_nowrite", mem[17], 32'd10);
      en = 1'b0;

      // Random programs against the model
      for (int t = 0; t < 25; t++) begin
         clear_mem();
         for (int i = 128; i < 256; i++)
            mem[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
         nins = $urandom_range(2, 6);
         for (int i = 0; i < nins; i++) begin
            c = ($urandom_range(0, 1) == 0) ? 32'(12 * (i + 1)) : 32'(12 * $urandom_range(0, nins - 1));
            put_instr(12 * i, 32'h200 + 32'(4 * $urandom_range(0, 127)),
                      32'h200 + 32'(4 * $urandom_range(0, 127)), c);
         end
         nmax = $urandom_range(1, 12);
         w    = $urandom_range(0, 3);
         run_prog($sformatf("rnd%0d", t), nmax, w);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/subleq_engine.md
SUBLEQ_ENGINE -- requirements
Module: subleq_engine

Interface
REQ-001 Parameters SHALL be: DW, 32, data/operand width; AW, 32, byte-address width (DW >= AW); WORD_BYTES, 4, address step per operand word; RESET_PC, 0, first instruction address; BR_LEQ, 1, 1 = branch on r <= 0, 0 = branch on r < 0.
REQ-002 Ports SHALL be, in order:
- clk, input, 1, sole clock.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, run enable.
- mem_req, output, 1, access request.
- mem_we, output, 1, write strobe.
- mem_addr, output, AW, byte address.
- mem_wdata, output, DW, write data.
- mem_rdata, input, DW, read data.
- mem_ack, input, 1, access complete.
- halted, output, 1, core stopped.
- pc_out, output, AW, current pc.
- instr_count, output, 32, retired instructions.
REQ-003 The design SHALL use one clock (clk); reset is synchronous and active-high (rst); all state changes on posedge clk.

Function
REQ-004 States SHALL be FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B and HALT, one-hot encoded.
REQ-005 Access addresses SHALL be: FETCH_A pc; FETCH_B pc+WORD_BYTES; FETCH_C pc+2*WORD_BYTES; READ_A opA; READ_B opB; WRITE_B opB.
REQ-006 Fetched operand words SHALL be truncated to their low AW bits to form opA, opB and opC.
REQ-007 mem_req SHALL be 1 in READ_A, READ_B, WRITE_B, FETCH_B and FETCH_C, and SHALL equal en in FETCH_A; it SHALL be 0 in HALT and during rst.
REQ-008 mem_we SHALL be 1 only in WRITE_B.
REQ-009 mem_wdata SHALL equal r = mem[opB] - mem[opA], computed modulo 2^DW.
REQ-010 In WRITE_B, mem_wdata SHALL be 0 when mem_req=0.
REQ-011 Handshake: mem_addr, mem_we and mem_wdata SHALL be held stable while mem_req=1 and mem_ack=0.
REQ-012 On a clock edge with mem_req=1 and mem_ack=1, the engine SHALL capture mem_rdata (read states) and advance to the next state; zero-wait operation (ack in the request cycle) SHALL give one access per cycle.
REQ-013 mem_ack SHALL be ignored when mem_req=0.
REQ-014 en SHALL be sampled only in FETCH_A; an instruction already begun SHALL complete even if en falls.
REQ-015 r SHALL be compared as signed DW-bit two's complement; the branch is taken if (BR_LEQ ? r <= 0 : r < 0).
REQ-016 On WRITE_B ack, pc SHALL become opC if the branch is taken, else pc+3*WORD_BYTES, modulo 2^AW; instr_count SHALL increment, wrapping at 2^32.
REQ-017 On WRITE_B ack, if the branch is taken and opC equals the current pc, the state SHALL go to HALT with halted=1, pc unchanged, and instr_count still incremented.
REQ-018 HALT SHALL be left only by rst.
REQ-019 Minimum latency SHALL be 6 cycles per instruction; each wait cycle adds 1.
REQ-020 pc_out SHALL equal the pc register.

Reset
REQ-021 While rst=1 the engine SHALL set: state FETCH_A, pc=RESET_PC, opA/opB/opC/operand data registers 0, halted 0, instr_count 0, mem_req 0, mem_we 0.
REQ-022 rst asserted mid-access SHALL abort that access with no write committed; a coincident mem_ack SHALL be ignored.

Structure
REQ-023 A shared package subleq_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-024 subleq_engine SHALL be a single module with no sub-module; the subtractor and compare SHALL be inline.

Verification
REQ-025 Zero-wait, DW=32, pc=0: words {0x40,0x44,0x100}, mem[0x40]=3, mem[0x44]=10 -> write 7 to 0x44 in cycle 6, pc=0x0C, instr_count=1.
REQ-026 Same program with mem[0x40]=10, mem[0x44]=10 -> r=0, pc=0x100; with BR_LEQ=0 -> pc=0x0C.
REQ-027 mem_ack delayed 3 cycles on every access -> addr/we/wdata stable throughout, instruction retires in 24 cycles, same memory result as REQ-025.
REQ-028 Instruction at 0x20 with opC=0x20 and r=-5 -> halted=1 after the write, mem_req=0 for the next 100 cycles, instr_count frozen.
REQ-029 rst pulsed during READ_B with ack pending -> mem_req=0 next cycle, no write issued, pc=RESET_PC; the fetch at RESET_PC begins in the first cycle after rst falls.
REQ-030 DW=8, mem[opB]=0x80, mem[opA]=0x01 -> writes 0x7F, branch not taken; en=0 at FETCH_A -> no request until en=1.
